turn_signal_monitor: RTL



---
 rtl/turn_signal_monitor.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/turn_signal_monitor.sv
// Receive-side checker for the turn-signal lamp buses: decodes direction, sweeps and
// steady-on, flags protocol faults, and drives an active-low status digit.
`timescale 1ns/1ps

module turn_signal_monitor #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int STEADY_CYCLES  = 50000000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] leftLights,
    input  logic [2:0] rightLights,
    output logic [1:0] active_dir,
    output logic [3:0] sweep_count,
    output logic       steady,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [6:0] hex
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_L,
        S_RUN_R,
        S_STEADY_L,
        S_STEADY_R,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] STEADY_C  = CNT_W'(STEADY_CYCLES - 1);

    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_L     = 7'b1000111;
    localparam logic [6:0] HEX_R     = 7'b0101111;
    localparam logic [6:0] HEX_E     = 7'b0000110;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_BOTH  = 2'b01;
    localparam logic [1:0] CODE_STEP  = 2'b10;
    localparam logic [1:0] CODE_STALL = 2'b11;

    function automatic logic pat_ok(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] s);
        case ({p, s})
            6'b000_001, 6'b001_011, 6'b011_111,
            6'b111_000, 6'b001_000, 6'b011_000: return 1'b1;
            default:                            return p == s;
        endcase
    endfunction

    logic [2:0]       r_l_s, r_r_s, r_l_p, r_r_p;
    logic [CNT_W-1:0] r_stable_cnt;
    state_t           r_state;
    logic [3:0]       r_sweep;
    logic [1:0]       r_code;
    logic [1:0]       r_active_dir;
    logic             r_steady;
    logic             r_fault;
    logic [6:0]       r_hex;

    logic             w_changed;
    logic             w_left_side;
    logic [2:0]       w_act_s, w_act_p, w_oth_s;
    state_t           w_nxt_state;
    logic [3:0]       w_nxt_sweep;
    logic [1:0]       w_nxt_code;
    logic [1:0]       w_nxt_dir;
    logic             w_nxt_steady;
    logic             w_nxt_fault;
    logic [6:0]       w_nxt_hex;

    assign w_changed   = {r_l_s, r_r_s} != {r_l_p, r_r_p};
    assign w_left_side = (r_state == S_RUN_L) || (r_state == S_STEADY_L);
    assign w_act_s     = w_left_side ? r_l_s : r_r_s;
    assign w_act_p     = w_left_side ? r_l_p : r_r_p;
    assign w_oth_s     = w_left_side ? r_r_s : r_l_s;

    // Sample stage: stable_cnt counts cycles the registered pair has matched its predecessor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l_s        <= '0;
            r_r_s        <= '0;
            r_l_p        <= '0;
            r_r_p        <= '0;
            r_stable_cnt <= '0;
        end else begin
            // NOTE: non-blocking so r_l_p takes the old r_l_s, forming a true two-stage history.
            r_l_s <= leftLights;
            r_r_s <= rightLights;
            r_l_p <= r_l_s;
            r_r_p <= r_r_s;
            if (w_changed)
                r_stable_cnt <= '0;
            else if (r_stable_cnt != '1)
                r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_nxt_state = r_state;
        w_nxt_sweep = r_sweep;
        w_nxt_code  = r_code;

        case (r_state)
            S_IDLE: begin
                if (r_l_s != 3'b000 && r_r_s != 3'b000) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_BOTH;
                end else if (r_l_s == 3'b001 && r_r_s == 3'b000) begin
                    w_nxt_state = S_RUN_L;
                    w_nxt_sweep = '0;
                end else if (r_r_s == 3'b001 && r_l_s == 3'b000) begin
                    w_nxt_state = S_RUN_R;
                    w_nxt_sweep = '0;
                end else if (r_l_s != 3'b000 || r_r_s != 3'b000) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_STEP;
                end
            end

            S_RUN_L, S_RUN_R: begin
                if (w_oth_s != 3'b000) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_BOTH;
                end else if (!pat_ok(w_act_s) || !step_ok(w_act_p, w_act_s)) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_STEP;
                end else if (w_act_p == 3'b111 && w_act_s == 3'b000) begin
                    if (r_sweep != 4'hF)
                        w_nxt_sweep = r_sweep + 4'd1;
                end else if (w_act_s == 3'b000 && w_act_p != 3'b000) begin
                    w_nxt_state = S_IDLE;
                end else if (!w_changed) begin
                    // Timers only apply once the bus has held still.
                    if ((w_act_s == 3'b001 || w_act_s == 3'b011) && r_stable_cnt >= TIMEOUT_C) begin
                        w_nxt_state = S_FAULT;
                        w_nxt_code  = CODE_STALL;
                    end else if (w_act_s == 3'b000 && r_stable_cnt >= TIMEOUT_C) begin
                        w_nxt_state = S_IDLE;
                    end else if (w_act_s == 3'b111 && r_stable_cnt >= STEADY_C) begin
                        w_nxt_state = w_left_side ? S_STEADY_L : S_STEADY_R;
                    end
                end
            end

            S_STEADY_L, S_STEADY_R: begin
                if (w_oth_s != 3'b000) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_BOTH;
                end else if (w_act_p == 3'b111 && w_act_s == 3'b000) begin
                    w_nxt_state = S_IDLE;
                end else if (w_act_s != w_act_p) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_code  = CODE_STEP;
                end
            end

            S_FAULT: begin
                if (r_l_s == 3'b000 && r_r_s == 3'b000 && !w_changed && r_stable_cnt >= TIMEOUT_C)
                    w_nxt_state = S_IDLE;
            end

            default: w_nxt_state = S_IDLE;
        endcase

        if (w_nxt_state == S_IDLE) begin
            w_nxt_sweep = '0;
            w_nxt_code  = CODE_NONE;
        end

        w_nxt_dir    = 2'b00;
        w_nxt_steady = 1'b0;
        w_nxt_fault  = 1'b0;
        w_nxt_hex    = HEX_BLANK;
        case (w_nxt_state)
            S_RUN_L:    begin w_nxt_dir = 2'b01; w_nxt_hex = HEX_L; end
            S_RUN_R:    begin w_nxt_dir = 2'b10; w_nxt_hex = HEX_R; end
            S_STEADY_L: begin w_nxt_dir = 2'b01; w_nxt_hex = HEX_L; w_nxt_steady = 1'b1; end
            S_STEADY_R: begin w_nxt_dir = 2'b10; w_nxt_hex = HEX_R; w_nxt_steady = 1'b1; end
            S_FAULT:    begin w_nxt_dir = 2'b11; w_nxt_hex = HEX_E; w_nxt_fault  = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sweep      <= '0;
            r_code       <= CODE_NONE;
            r_active_dir <= 2'b00;
            r_steady     <= 1'b0;
            r_fault      <= 1'b0;
            r_hex        <= HEX_BLANK;
        end else begin
            r_state      <= w_nxt_state;
            r_sweep      <= w_nxt_sweep;
            r_code       <= w_nxt_code;
            r_active_dir <= w_nxt_dir;
            r_steady     <= w_nxt_steady;
            r_fault      <= w_nxt_fault;
            r_hex        <= w_nxt_hex;
        end
    end

    assign active_dir  = r_active_dir;
    assign sweep_count = r_sweep;
    assign steady      = r_steady;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign hex         = r_hex;

endmodule
